instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 20 ++
 rtl/instr_sequencer_prog_mem.sv | 26 ++
 rtl/instr_sequencer.sv | 126 ++++++++++++
 tb/tb_instr_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode constants,
// opcode field geometry and FSM state encoding.
package instr_sequencer_pkg;

  // The opcode always occupies the top OP_WIDTH bits of an instruction word.
  localparam int OP_WIDTH = 4;

  typedef logic [OP_WIDTH-1:0] opcode_t;

  localparam opcode_t OP_HALT = 4'hF;
  localparam opcode_t OP_JMP  = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_HALT
  } state_t;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: single write port, synchronous read port, write-first so a
// word written on the same edge it is read is returned immediately.
module instr_sequencer_prog_mem #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // NOTE: the array has no reset on purpose; it maps onto RAM and the program
  // must survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetches words from a small program store and hands them to a CPU over a
// valid/ready handshake, executing HALT and JMP locally.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic                   cpu_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   issued_count
);

  state_t                 state, state_next;
  logic [PC_BITS-1:0]     pc_next;
  logic [INSTR_WIDTH-1:0] instr_next;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   valid_next;
  logic                   done_next;
  logic [CNT_WIDTH-1:0]   count_next;
  logic                   mem_wr_en;
  opcode_t                fetched_op;
  opcode_t                held_op;

  assign fetched_op = rd_data[INSTR_WIDTH-1 -: OP_WIDTH];
  assign held_op    = instruction[INSTR_WIDTH-1 -: OP_WIDTH];
  assign mem_wr_en  = load_en && ((state == ST_IDLE) || (state == ST_HALT));

  // The read is launched with the pc being loaded, so the word is already in
  // rd_data during FETCH and instr_valid can be registered on entry to ISSUE.
  instr_sequencer_prog_mem #(
    .DATA_WIDTH(INSTR_WIDTH),
    .ADDR_BITS (PC_BITS)
  ) prog_mem (
    .clk    (clk),
    .wr_en  (mem_wr_en),
    .wr_addr(load_addr),
    .wr_data(load_data),
    .rd_addr(pc_next),
    .rd_data(rd_data)
  );

  // NOTE: every output of this block gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instruction;
    valid_next = instr_valid;
    done_next  = done;
    count_next = issued_count;

    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_next = ST_FETCH;
          pc_next    = '0;
          count_next = '0;
          done_next  = 1'b0;
        end
      end

      ST_FETCH: begin
        state_next = ST_ISSUE;
        instr_next = rd_data;
        valid_next = (fetched_op != OP_HALT) && (fetched_op != OP_JMP);
      end

      ST_ISSUE: begin
        if (held_op == OP_HALT) begin
          state_next = ST_HALT;
          done_next  = 1'b1;
        end else if (held_op == OP_JMP) begin
          state_next = ST_FETCH;
          pc_next    = instruction[PC_BITS-1:0];
        end else if (cpu_ready) begin
          valid_next = 1'b0;
          if (issued_count != {CNT_WIDTH{1'b1}}) begin
            count_next = issued_count + 1'b1;
          end
          // The last address halts instead of wrapping back to 0.
          if (pc == {PC_BITS{1'b1}}) begin
            state_next = ST_HALT;
            done_next  = 1'b1;
          end else begin
            state_next = ST_FETCH;
            pc_next    = pc + 1'b1;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pc           <= '0;
      instruction  <= '0;
      instr_valid  <= 1'b0;
      done         <= 1'b0;
      issued_count <= '0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      instruction  <= instr_next;
      instr_valid  <= valid_next;
      done         <= done_next;
      issued_count <= count_next;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, hand-written
// corner sequences and random programs against an interpreter model.
module tb_instr_sequencer;

  localparam int IW = 20;
  localparam int PB = 5;
  localparam int CW = 8;
  localparam logic [3:0] HALT_OP = 4'hF;
  localparam logic [3:0] JMP_OP  = 4'hE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [PB-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic          cpu_ready = 1'b0;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic [PB-1:0] pc;
  logic          done;
  logic [CW-1:0] issued_count;

  instr_sequencer #(.INSTR_WIDTH(IW), .PC_BITS(PB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .cpu_ready(cpu_ready),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .done(done), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [IW-1:0] got_q[$];
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] prog[32];
  int            first_cyc;
  int            done_cyc;
  logic [IW-1:0] first_word;
  int            stall_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int addr, input logic [IW-1:0] data);
    load_en = 1'b1; load_addr = PB'(addr); load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check({name, ".instruction"}, instruction, 0);
    check({name, ".valid"}, instr_valid, 0);
    check({name, ".pc"}, pc, 0);
    check({name, ".done"}, done, 0);
    check({name, ".count"}, issued_count, 0);
  endtask

  // Pulses start and runs until done; stall holds cpu_ready low for that many
  // cycles of the first valid word, rnd randomises cpu_ready every cycle.
  task automatic run(input int stall, input bit rnd, input int budget);
    got_q.delete();
    first_cyc = -1; done_cyc = -1; stall_left = stall;
    cpu_ready = (stall == 0);
    start = 1'b1;
    tick();
    start = 1'b0; load_en = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (done) begin done_cyc = c; break; end
      if (instr_valid && first_cyc < 0) begin first_cyc = c; first_word = instruction; end
      if (rnd) cpu_ready = ($urandom_range(2, 0) != 0);
      else if (instr_valid && stall_left > 0) begin cpu_ready = 1'b0; stall_left--; end
      else cpu_ready = 1'b1;
      tick();
    end
    check("run.halted_within_budget", done_cyc > 0, 1);
  endtask

  // Interprets the program: HALT stops, JMP redirects, anything else is
  // delivered once; the last address stops without wrapping.
  task automatic run_model(output logic [PB-1:0] fpc);
    int p = 0;
    logic [3:0] op;
    exp_q.delete();
    for (int steps = 0; steps < 200; steps++) begin
      op = prog[p][IW-1 -: 4];
      if (op == HALT_OP) break;
      if (op == JMP_OP) begin p = int'(prog[p][PB-1:0]); continue; end
      exp_q.push_back(prog[p]);
      if (p == 31) break;
      p++;
    end
    fpc = PB'(p);
  endtask

  // Transfer capture and stall-stability monitor, sampled mid-cycle.
  logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;
  logic [IW-1:0] prev_instr = '0;
  always @(negedge clk) begin
    if (!rst && instr_valid && cpu_ready) got_q.push_back(instruction);
    if (prev_valid && !prev_ready && !prev_rst) begin
      check("stall_hold.valid", instr_valid, 1);
      check("stall_hold.word", instruction, prev_instr);
    end
    prev_valid = instr_valid; prev_ready = cpu_ready;
    prev_rst = rst; prev_instr = instruction;
  end

  typedef struct {
    string         name;
    logic [IW-1:0] w0, w1, w2;
    int            stall;
    logic [IW-1:0] exp_first;
    int            exp_first_cyc;
    int            exp_done_cyc;
    int            exp_cnt;
    logic [PB-1:0] exp_pc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PB-1:0] model_pc;
    logic [IW-1:0] words[32];
    int r;

    vecs[0] = '{"basic",   20'h10203, 20'h20405, 20'hF0000, 0, 20'h10203, 2,  7, 2, 5'd2};
    vecs[1] = '{"stall5",  20'h10203, 20'h20405, 20'hF0000, 5, 20'h10203, 2, 12, 2, 5'd2};
    vecs[2] = '{"halt0",   20'hF0000, 20'h10000, 20'h10000, 0, 20'h00000, -1, 3, 0, 5'd0};
    vecs[3] = '{"jmp2",    20'hE0002, 20'h11111, 20'h3ABCD, 0, 20'h3ABCD, 4,  7, 1, 5'd3};
    vecs[4] = '{"jmp31",   20'hE001F, 20'h12345, 20'h12345, 0, 20'h00000, -1, 5, 0, 5'd31};
    vecs[5] = '{"opedges", 20'hD0001, 20'h00002, 20'hF0000, 0, 20'hD0001, 2,  7, 2, 5'd2};

    repeat (3) tick();
    rst = 1'b0;
    check_zero("reset");
    tick();
    check_zero("idle_hold");

    for (int a = 0; a < 32; a++) load_word(a, 20'hF0000);

    foreach (vecs[i]) begin
      load_word(0, vecs[i].w0);
      load_word(1, vecs[i].w1);
      load_word(2, vecs[i].w2);
      run(vecs[i].stall, 1'b0, 100);
      check({vecs[i].name, ".first_cycle"}, first_cyc, vecs[i].exp_first_cyc);
      check({vecs[i].name, ".done_cycle"}, done_cyc, vecs[i].exp_done_cyc);
      check({vecs[i].name, ".transfers"}, got_q.size(), vecs[i].exp_cnt);
      check({vecs[i].name, ".count"}, issued_count, vecs[i].exp_cnt);
      check({vecs[i].name, ".pc"}, pc, vecs[i].exp_pc);
      check({vecs[i].name, ".valid_in_halt"}, instr_valid, 0);
      if (got_q.size() > 0) check({vecs[i].name, ".first_word"}, got_q[0], vecs[i].exp_first);
    end

    // Write and start in the same cycle: the fresh word must be fetched.
    load_word(1, 20'hF0000);
    load_en = 1'b1; load_addr = '0; load_data = 20'h51234;
    run(0, 1'b0, 50);
    check("same_cycle.first_word", first_word, 20'h51234);
    check("same_cycle.count", issued_count, 1);

    // Full memory of plain words: 32 transfers, halt at the top address.
    for (int a = 0; a < 32; a++) begin
      words[a] = {4'(a % 14), 16'(a * 7 + 1)};
      load_word(a, words[a]);
    end
    run(0, 1'b0, 200);
    check("fill.transfers", got_q.size(), 32);
    for (int a = 0; a < 32 && a < got_q.size(); a++) check($sformatf("fill.word%0d", a), got_q[a], words[a]);
    check("fill.pc", pc, 31);
    check("fill.count", issued_count, 32);
    check("fill.done", done, 1);

    // Reset during a stalled ISSUE, then restart from the preserved program.
    load_word(0, 20'h77777);
    load_word(1, 20'hF0000);
    cpu_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 10 && !instr_valid; c++) tick();
    tick(); tick();
    check("rst_mid.stalled_valid", instr_valid, 1);
    check("rst_mid.stalled_word", instruction, 20'h77777);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("rst_mid");
    run(0, 1'b0, 50);
    check("rst_mid.reissue_word", first_word, 20'h77777);
    check("rst_mid.reissue_transfers", got_q.size(), 1);
    check("rst_mid.count", issued_count, 1);

    // Endless loop: counter saturates; loads and starts while running are ignored.
    load_word(0, 20'h20001);
    load_word(1, 20'hE0000);
    cpu_ready = 1'b1; start = 1'b1;
    tick();
    for (int c = 1; c < 1100; c++) begin
      load_en = (c % 97 == 5); load_addr = '0; load_data = 20'hF0000;
      start = (c % 150 == 7) || (c == 1090);
      tick();
    end
    load_en = 1'b0; start = 1'b0;
    check("sat.count", issued_count, 255);
    check("sat.done", done, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("rst_sat");
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("sat.mem_kept_valid", instr_valid, 1);
    check("sat.mem_kept_word", instruction, 20'h20001);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Random programs with forward-only jumps, random cpu_ready.
    for (int t = 0; t < 25; t++) begin
      for (int p = 0; p < 32; p++) begin
        r = int'($urandom_range(99, 0));
        if (r < 10) prog[p] = {HALT_OP, 16'($urandom)};
        else if (r < 25 && p < 31) prog[p] = {JMP_OP, 11'($urandom), 5'($urandom_range(31, p + 1))};
        else prog[p] = {4'($urandom_range(13, 0)), 16'($urandom)};
        load_word(p, prog[p]);
      end
      run_model(model_pc);
      run(0, 1'b1, 2000);
      check($sformatf("rand%0d.transfers", t), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check($sformatf("rand%0d.word%0d", t, i), got_q[i], exp_q[i]);
      check($sformatf("rand%0d.count", t), issued_count, exp_q.size());
      check($sformatf("rand%0d.pc", t), pc, model_pc);
      check($sformatf("rand%0d.done", t), done, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
